// File: rtl/cortex_m0_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-bus signals around the arbiter.
// slave = arbiter side, master = core/memory side driving it.
interface cortex_m0_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;

  logic          ls_req;
  logic          ls_write;
  logic [1:0]    ls_size;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [DW-1:0] ls_rdata;
  logic          ls_done;
  logic          ls_err;

  logic          mem_req;
  logic          mem_write;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done,
    input  ls_req, ls_write, ls_size, ls_addr, ls_wdata,
    output ls_rdata, ls_done, ls_err,
    output mem_req, mem_write, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done,
    output ls_req, ls_write, ls_size, ls_addr, ls_wdata,
    input  ls_rdata, ls_done, ls_err,
    input  mem_req, mem_write, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cortex_m0_mem_arbiter.sv
// Single-outstanding memory bus arbiter between fetch and load/store ports.
// Load/store has priority; a starvation counter forces a fetch grant.
module cortex_m0_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  cortex_m0_mem_arbiter_if.slave  bus,
  output logic [1:0]              owner
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_IF     = 2'b01;
  localparam logic [1:0] OWN_LS     = 2'b10;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_write_q, mem_write_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;
  logic          if_done_q, if_done_d;
  logic          ls_done_q, ls_done_d;
  logic          ls_err_q, ls_err_d;

  logic          fetch_win, ls_win, ls_legal;
  logic [AW-1:0] if_addr_al;

  assign if_addr_al = bus.if_addr & ~AW'(3);
  assign fetch_win  = bus.if_req && (!bus.ls_req || starve_q == STARVE_LIM);
  assign ls_win     = !fetch_win && bus.ls_req;

  always_comb begin
    ls_legal = 1'b0;
    case (bus.ls_size)
      2'b00:   ls_legal = 1'b1;
      2'b01:   ls_legal = !bus.ls_addr[0];
      2'b10:   ls_legal = (bus.ls_addr[1:0] == 2'b00);
      default: ls_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    ls_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // a fetch that loses here can only have lost to load/store
        if (!bus.if_req || fetch_win)   starve_d = 4'd0;
        else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
        if (fetch_win) begin
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_size_d  = 2'b10;
          mem_addr_d  = if_addr_al;
          mem_wdata_d = '0;
          owner_d     = OWN_IF;
          state_d     = BUSY;
        end else if (ls_win && ls_legal) begin
          mem_req_d   = 1'b1;
          mem_write_d = bus.ls_write;
          mem_size_d  = bus.ls_size;
          mem_addr_d  = bus.ls_addr;
          mem_wdata_d = bus.ls_wdata;
          owner_d     = OWN_LS;
          state_d     = BUSY;
        end else if (ls_win) begin
          ls_done_d  = 1'b1;
          ls_err_d   = 1'b1;
          ls_rdata_d = '0;
          state_d    = RESP;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = bus.mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            ls_rdata_d = mem_write_q ? '0 : bus.mem_rdata;
            ls_done_d  = 1'b1;
          end
        end
      end
      RESP: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      ls_err_q    <= ls_err_d;
    end
  end

  assign owner         = owner_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.ls_err    = ls_err_q;
endmodule
